// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - per-output-port switch allocator, round-robin (ARB_FIXED_PRIO_EN selects fixed priority)
module port_arbiter #(
  parameter int NPORT   = 5,
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             credit_in,
  output logic [NPORT-1:0] grant,
  output logic [NPORT-1:0] pop,
  output logic             valid_out,
  output logic             busy,
  output logic [CW-1:0]    credits,
  output logic             credit_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int         PW        = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [0:0]       state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [NPORT-1:0] win_oh;
  logic [CW-1:0]    credits_q, credits_d;
  logic             credit_err_q, credit_err_d;
  logic             xfer;
  logic             tail_g;

  // A flit moves only while locked, the granted input has a flit and downstream has room.
  assign xfer      = (state_q == ST_LOCKED) && (|(req & grant_q)) && (credits_q != '0);
  assign tail_g    = |(tail & grant_q);
  assign pop       = xfer ? grant_q : '0;
  assign valid_out = |pop;

  assign grant      = grant_q;
  assign busy       = (state_q == ST_LOCKED);
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index is the last writer.
  always_comb begin
    win_oh = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_oh    = '0;
        win_oh[k] = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] g_idx;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Round-robin: first requester at or after ptr, wrapping modulo NPORT.
  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NPORT)) begin
        sum = sum - (PW+1)'(NPORT);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Encode the one-hot grant so the pointer can move just past the finished input.
  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (grant_q[k]) begin
        g_idx = PW'(k);
      end
    end
  end

  // Pointer advances only when a packet completes, giving the next input first chance.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && tail_g) begin
      ptr_d = (g_idx == PW'(NPORT - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Lock onto the winner from head to tail; release forces one idle cycle between packets.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_LOCKED;
          grant_d = win_oh;
        end
      end
      default: begin
        if (xfer && tail_g) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  // Credit counter: saturates at CREDITS and flags an overflow stickily.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    case ({xfer, credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CW'(CREDITS)) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, grant and credit registers; reset aborts any lock at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      credits_q    <= CW'(CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - directed self-checking bench for port_arbiter
module tb_port_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_in;
  logic [4:0] grant;
  logic [4:0] pop;
  logic       valid_out;
  logic       busy;
  logic [2:0] credits;
  logic       credit_err;

  int checks   = 0;
  int failures = 0;

  port_arbiter #(.NPORT(5), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .pop        (pop),
    .valid_out  (valid_out),
    .busy       (busy),
    .credits    (credits),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; tail = '0; credit_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; tail = '0; credit_in = 1'b0;
    #12;
    checks++; if (grant !== 5'b00000) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grant, 5'b00000); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (credits !== 3'd4) begin failures++; $display("FAIL reset_credits got=%0d exp=4", credits); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", credit_err); end
    checks++; if (pop !== 5'b00000 || valid_out !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b/%b exp=00000/0", pop, valid_out); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); req = 5'b00100; tail = 5'b00100; #1;
    checks++; if (pop !== 5'b00000) begin failures++; $display("FAIL single_idle_pop got=%b exp=00000", pop); end
    @(negedge clk); #1;
    checks++; if (grant !== 5'b00100) begin failures++; $display("FAIL single_grant got=%b exp=00100", grant); end
    checks++; if (pop !== 5'b00100 || valid_out !== 1'b1) begin failures++; $display("FAIL single_pop got=%b/%b exp=00100/1", pop, valid_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(negedge clk); req = '0; tail = '0; #1;
    checks++; if (grant !== 5'b00000 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=00000/0", grant, busy); end
    checks++; if (credits !== 3'd3) begin failures++; $display("FAIL single_credits got=%0d exp=3", credits); end
    @(negedge clk); credit_in = 1'b1;
    @(negedge clk); credit_in = 1'b0; #1;
    checks++; if (credits !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL single_refill got=%0d/%b exp=4/0", credits, credit_err); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g [6];
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`else
    exp_g = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
`endif
    do_reset();
    for (int p = 0; p < 6; p++) begin
      @(negedge clk); req = 5'b11111; tail = '0; credit_in = 1'b0; #1;
      checks++; if (grant !== 5'b00000) begin failures++; $display("FAIL rr_idle_gap pkt=%0d got=%b exp=00000", p, grant); end
      @(negedge clk); tail = '0; credit_in = 1'b1; #1;
      checks++; if (grant !== exp_g[p] || pop !== exp_g[p]) begin failures++; $display("FAIL rr_grant pkt=%0d got=%b/%b exp=%b", p, grant, pop, exp_g[p]); end
      @(negedge clk); tail = 5'b11111; credit_in = 1'b1; #1;
      checks++; if (pop !== exp_g[p]) begin failures++; $display("FAIL rr_tail_pop pkt=%0d got=%b exp=%b", p, pop, exp_g[p]); end
    end
    @(negedge clk); req = '0; tail = '0; credit_in = 1'b0; #1;
    checks++; if (credits !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL rr_credits got=%0d/%b exp=4/0", credits, credit_err); end
  endtask

  task automatic test_credit_stall();
    int pops;
    do_reset();
    @(negedge clk); req = 5'b00010; tail = '0; #1;
    pops = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      if (pop == 5'b00010) pops++;
    end
    checks++; if (pops !== 4) begin failures++; $display("FAIL stall_pops got=%0d exp=4", pops); end
    checks++; if (credits !== 3'd0) begin failures++; $display("FAIL stall_credits got=%0d exp=0", credits); end
    checks++; if (grant !== 5'b00010 || busy !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b/%b exp=00010/1", grant, busy); end
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      credit_in = (i == 0 || i == 2);
      tail = (i == 3) ? 5'b00010 : 5'b00000;
      req  = (i < 4) ? 5'b00010 : 5'b00000;
      #1;
      if (pop == 5'b00010) pops++;
    end
    checks++; if (pops !== 2) begin failures++; $display("FAIL stall_release_pops got=%0d exp=2", pops); end
    checks++; if (grant !== 5'b00000 || busy !== 1'b0 || credits !== 3'd0) begin failures++; $display("FAIL stall_end got=%b/%b/%0d exp=00000/0/0", grant, busy, credits); end
  endtask

  task automatic test_bubble();
    do_reset();
    @(negedge clk); req = 5'b01000; tail = '0; #1;
    @(negedge clk); #1;
    checks++; if (grant !== 5'b01000 || pop !== 5'b01000) begin failures++; $display("FAIL bubble_lock got=%b/%b exp=01000", grant, pop); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req = 5'b00001; #1;
      checks++; if (pop !== 5'b00000 || grant !== 5'b01000) begin failures++; $display("FAIL bubble_hold cyc=%0d got=%b/%b exp=00000/01000", i, pop, grant); end
    end
    @(negedge clk); req = 5'b01000; tail = 5'b01000; #1;
    checks++; if (pop !== 5'b01000) begin failures++; $display("FAIL bubble_resume got=%b exp=01000", pop); end
    @(negedge clk); req = '0; tail = '0; #1;
    checks++; if (grant !== 5'b00000 || credits !== 3'd2) begin failures++; $display("FAIL bubble_end got=%b/%0d exp=00000/2", grant, credits); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(negedge clk); req = 5'b00001; tail = '0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (credits !== 3'd3) begin failures++; $display("FAIL same_pre got=%0d exp=3", credits); end
    @(negedge clk); credit_in = 1'b1; #1;
    checks++; if (credits !== 3'd2 || pop !== 5'b00001) begin failures++; $display("FAIL same_setup got=%0d/%b exp=2/00001", credits, pop); end
    @(negedge clk); credit_in = 1'b0; req = '0; #1;
    checks++; if (credits !== 3'd2) begin failures++; $display("FAIL same_cycle got=%0d exp=2", credits); end
  endtask

  task automatic test_overflow_async_reset();
    do_reset();
    @(negedge clk); credit_in = 1'b1; #1;
    checks++; if (credits !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%0d/%b exp=4/0", credits, credit_err); end
    @(negedge clk); credit_in = 1'b0; #1;
    checks++; if (credits !== 3'd4 || credit_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d/%b exp=4/1", credits, credit_err); end
    @(negedge clk); req = 5'b00100; tail = '0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (credit_err !== 1'b1 || credits !== 3'd3 || grant !== 5'b00100) begin failures++; $display("FAIL ovf_sticky got=%b/%0d/%b exp=1/3/00100", credit_err, credits, grant); end
    #2; rst = 1'b0; #1;
    checks++; if (grant !== 5'b00000 || busy !== 1'b0) begin failures++; $display("FAIL async_grant got=%b/%b exp=00000/0", grant, busy); end
    checks++; if (credits !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL async_credits got=%0d/%b exp=4/0", credits, credit_err); end
    checks++; if (pop !== 5'b00000 || valid_out !== 1'b0) begin failures++; $display("FAIL async_pop got=%b/%b exp=00000/0", pop, valid_out); end
    @(negedge clk); req = '0; rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_bubble();
    test_same_cycle();
    test_overflow_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Per-output-port switch allocator for the 5-port mesh router. Collects routing requests from the five input buffers for one output port and grants exactly one input at a time, round-robin. It holds the grant from a packet's head flit through its tail flit and only passes flits when the downstream buffer has credit. The registered one-hot `grant` drives the crossbar select for that output; `pop` dequeues the granted input buffer.

## Interface
Parameters:
- `NPORT`, default 5: number of router input ports.
- `CREDITS`, default 4: downstream input-buffer depth in flits; initial credit count.
- `CW`, default `$clog2(CREDITS+1)`: credit counter width.

Ports:
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `req`  input  NPORT: bit i high means input i's head-of-queue flit is routed to this output.
- `tail`  input  NPORT: bit i high means input i's head-of-queue flit is a tail flit. Single-flit packets have head and tail set together.
- `credit_in`  input  1: one-cycle pulse; downstream freed one buffer slot.
- `grant`  output  NPORT: registered one-hot crossbar select; all zeros when idle.
- `pop`  output  NPORT: combinational one-hot; input i dequeues a flit this cycle.
- `valid_out`  output  1: combinational; a flit crosses to the output this cycle. Equals OR of `pop`.
- `busy`  output  1: registered; high in LOCKED.
- `credits`  output  CW: registered current credit count.
- `credit_err`  output  1: registered, sticky; set on credit overflow.

## Operation
- States: IDLE and LOCKED.
- IDLE:
  - `grant` is 0.
  - If `req` is nonzero, select the winner by round-robin search starting at `ptr`, wrapping modulo NPORT.
  - Next cycle: `grant` becomes the winner's one-hot value and the state becomes LOCKED.
  - If `req` is 0, stay in IDLE.
- LOCKED, with g the granted index:
  - Transfer condition: `req[g]` high and `credits` nonzero.
  - On transfer: `pop[g]=1` and `valid_out=1`.
  - Transfer with `tail[g]` high: next state IDLE, `grant` becomes 0, and `ptr` becomes (g+1) mod NPORT.
  - `req[g]` low (upstream bubble) or `credits` zero: no transfer, and the grant is held.
  - Requests from other inputs are ignored while LOCKED.
- `pop` bits other than g are always 0. `pop` is all zeros in IDLE.
- Credit counter:
  - Decrement by 1 on transfer.
  - Increment by 1 on `credit_in`.
  - Transfer and `credit_in` in the same cycle: counter unchanged.
  - `credit_in` at `CREDITS` with no transfer: counter stays at `CREDITS` and `credit_err` is set, held until reset.
  - Underflow cannot occur because transfer is gated by `credits` nonzero.
- `credits` is unsigned, CW bits wide, and never exceeds `CREDITS`.

## Timing
- Reset values: `grant`=0, `busy`=0, `credits`=`CREDITS`, `credit_err`=0, state IDLE, `ptr`=0. With these values, `pop` and `valid_out` are 0.
- Reset asserted mid-packet aborts the lock immediately. Recovery of the partial packet is the upstream's responsibility.
- Arbitration latency is 1 cycle:
  - `req` seen in IDLE at cycle n gives `grant`/`busy` at n+1.
  - The first `pop` can occur at n+1.
- Throughput while LOCKED: 1 flit per cycle while `req[g]` is high and credit is available.
- Tail popped at cycle k: `grant`=0 at k+1, and the next grant appears at k+2 at the earliest. There is one mandatory idle cycle between packets.
- `credit_in` at cycle k is usable for a transfer at k+1.

## Configuration
- `ARB_FIXED_PRIO_EN` defined:
  - IDLE arbitration is fixed priority, lowest index wins (input 0 highest).
  - `ptr` is not implemented.
- `ARB_FIXED_PRIO_EN` not defined (default): round-robin as described in Operation.

## Test plan
- Reset, then `req`=5'b00100 with `tail`=5'b00100 for one flit:
  - `grant`=5'b00100 next cycle, with `pop[2]` pulsed.
  - The cycle after: `grant`=0 and `credits`=3.
- `req`=5'b11111 held, each packet 2 flits, credits replenished every cycle:
  - Grants rotate 0,1,2,3,4,0.
  - With `ARB_FIXED_PRIO_EN`, input 0 is granted every time.
- Input 1 locked with a 6-flit packet and no `credit_in`:
  - Exactly 4 pops, then `credits`=0 and stall with `grant` held.
  - Two `credit_in` pulses release exactly 2 more pops.
- While LOCKED on input 3, drop `req[3]` for 3 cycles and raise `req[0]`:
  - No pops and no grant change.
  - Transfer resumes on input 3 when `req[3]` returns.
- Transfer and `credit_in` in the same cycle at `credits`=2: stays 2.
- `credit_in` at `credits`=4 with no transfer: stays 4 and `credit_err`=1 until reset.
- Assert `rst` low mid-packet: `grant`=0, `busy`=0, `credits`=4 immediately, without waiting for a clock edge.
